// File: rtl/ring_check_pkg.sv
// Shared types for ring-bus monitors: checker FSM states and sample classes.
package ring_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_ONEHOT,
        CLS_MULTI
    } cls_t;

endpackage

// File: rtl/ring_counter_checker_onehot_classify.sv
// Combinational classifier for a WIDTH-bit bus: zero / one-hot / multi-bit, plus
// the binary position of the set bit when the bus is one-hot.
module onehot_classify
    import ring_check_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output cls_t             o_cls,
    output logic [IDX_W-1:0] o_idx
);

    logic w_seen;
    logic w_multi;

    always_comb begin
        w_seen  = 1'b0;
        w_multi = 1'b0;
        o_idx   = '0;
        o_cls   = CLS_ZERO;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) begin
                w_multi = w_multi | w_seen;
                w_seen  = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
        if (w_multi) begin
            o_cls = CLS_MULTI;
        end else if (w_seen) begin
            o_cls = CLS_ONEHOT;
        end
    end

endmodule

// File: rtl/ring_counter_checker.sv
// On-chip monitor for a one-hot ring bus: encodes, checks single-step advance,
// locks after LOCK_CNT good steps and counts errors. RING_CHECK_STICKY_ERR_EN adds err_sticky.
module ring_counter_checker
    import ring_check_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned LOCK_CNT  = 2,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     presetn,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         ring_in,
    output logic [$clog2(WIDTH)-1:0] idx_out,
    output logic                     idx_valid,
    output logic                     locked,
    output logic                     err_pulse,
    output logic [ERR_CNT_W-1:0]     err_count
`ifdef RING_CHECK_STICKY_ERR_EN
    ,
    output logic                     err_sticky
`endif
);

    localparam int unsigned IDX_W  = $clog2(WIDTH);
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [GOOD_W-1:0]    LOCK_TGT = GOOD_W'(LOCK_CNT);
    localparam logic [GOOD_W-1:0]    GOOD_ONE = GOOD_W'(1);
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);

    cls_t               w_cls;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_exp;
    logic               w_step_ok;
    logic [GOOD_W-1:0]  w_good_inc;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GOOD_W-1:0]  r_good_cnt;
    logic [GOOD_W-1:0]  w_good_nxt;
    logic               w_err;

    // idx_out and prev_idx share a register: both load only on one-hot samples.
    logic [IDX_W-1:0]     r_idx;
    logic                 r_idx_valid;
    logic                 r_locked;
    logic                 r_err_pulse;
    logic [ERR_CNT_W-1:0] r_err_count;

    onehot_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .i_vec (ring_in),
        .o_cls (w_cls),
        .o_idx (w_idx)
    );

    // WIDTH is a power of two, so the natural IDX_W-bit wrap gives mod WIDTH.
    assign w_exp      = r_idx + IDX_ONE;
    assign w_step_ok  = (w_idx == w_exp);
    assign w_good_inc = r_good_cnt + GOOD_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_err       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_cls == CLS_ONEHOT) begin
                    w_state_nxt = ACQUIRE;
                    w_good_nxt  = '0;
                end else if (w_cls == CLS_MULTI) begin
                    w_err = 1'b1;
                end
            end
            ACQUIRE: begin
                if (w_cls == CLS_ONEHOT) begin
                    if (!w_step_ok) begin
                        w_good_nxt = '0;
                    end else if (w_good_inc == LOCK_TGT) begin
                        w_state_nxt = LOCKED;
                        w_good_nxt  = '0;
                    end else begin
                        w_good_nxt = w_good_inc;
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_good_nxt  = '0;
                    w_err       = (w_cls == CLS_MULTI);
                end
            end
            LOCKED: begin
                if (w_cls == CLS_ONEHOT) begin
                    if (!w_step_ok) begin
                        w_state_nxt = ACQUIRE;
                        w_good_nxt  = '0;
                        w_err       = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_good_nxt  = '0;
                    w_err       = (w_cls == CLS_MULTI);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_good_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge presetn) begin
        if (!presetn) begin
            r_state     <= IDLE;
            r_good_cnt  <= '0;
            r_idx       <= '0;
            r_idx_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else if (enable) begin
            r_state     <= w_state_nxt;
            r_good_cnt  <= w_good_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_idx_valid <= (w_cls == CLS_ONEHOT);
            r_err_pulse <= w_err;
            if (w_cls == CLS_ONEHOT) begin
                r_idx <= w_idx;
            end
            if (w_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + ERR_ONE;
            end
        end else begin
            r_idx_valid <= 1'b0;
            r_err_pulse <= 1'b0;
        end
    end

`ifdef RING_CHECK_STICKY_ERR_EN
    logic r_err_sticky;

    always_ff @(posedge clk or negedge presetn) begin
        if (!presetn) begin
            r_err_sticky <= 1'b0;
        end else if (enable && w_err) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign err_sticky = r_err_sticky;
`endif

    assign idx_out   = r_idx;
    assign idx_valid = r_idx_valid;
    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_ring_counter_checker.sv
// Directed scoreboard bench for ring_counter_checker: default instance plus an
// ERR_CNT_W=2 instance for counter saturation.
module tb_ring_counter_checker;

    logic       clk = 1'b0;
    logic       presetn;
    logic       en1, en2;
    logic [3:0] ring1, ring2;

    logic [1:0] idx1, idx2;
    logic       valid1, valid2, locked1, locked2, pulse1, pulse2;
    logic [7:0] cnt1;
    logic [1:0] cnt2;
`ifdef RING_CHECK_STICKY_ERR_EN
    logic       sticky1, sticky2;
`endif

    always #5 clk = ~clk;

    ring_counter_checker #(
        .WIDTH     (4),
        .LOCK_CNT  (2),
        .ERR_CNT_W (8)
    ) dut (
        .clk       (clk),
        .presetn   (presetn),
        .enable    (en1),
        .ring_in   (ring1),
        .idx_out   (idx1),
        .idx_valid (valid1),
        .locked    (locked1),
        .err_pulse (pulse1),
        .err_count (cnt1)
`ifdef RING_CHECK_STICKY_ERR_EN
        ,
        .err_sticky (sticky1)
`endif
    );

    ring_counter_checker #(
        .WIDTH     (4),
        .LOCK_CNT  (2),
        .ERR_CNT_W (2)
    ) dut_sat (
        .clk       (clk),
        .presetn   (presetn),
        .enable    (en2),
        .ring_in   (ring2),
        .idx_out   (idx2),
        .idx_valid (valid2),
        .locked    (locked2),
        .err_pulse (pulse2),
        .err_count (cnt2)
`ifdef RING_CHECK_STICKY_ERR_EN
        ,
        .err_sticky (sticky2)
`endif
    );

    typedef struct packed {
        logic [1:0] idx;
        logic       valid;
        logic       locked;
        logic       pulse;
        logic [7:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    function automatic exp_t E(input logic [1:0] idx, input logic v, input logic l,
                               input logic p, input logic [7:0] c);
        exp_t e;
        e.idx = idx; e.valid = v; e.locked = l; e.pulse = p; e.cnt = c;
        return e;
    endfunction

    function automatic exp_t observe(input bit sel);
        exp_t o;
        if (sel) o = E(idx2, valid2, locked2, pulse2, {6'b0, cnt2});
        else     o = E(idx1, valid1, locked1, pulse1, cnt1);
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit sel, input exp_t e);
        exp_t o;
        o = observe(sel);
        chk({tag, ".idx_out"},   32'(o.idx),    32'(e.idx));
        chk({tag, ".idx_valid"}, 32'(o.valid),  32'(e.valid));
        chk({tag, ".locked"},    32'(o.locked), 32'(e.locked));
        chk({tag, ".err_pulse"}, 32'(o.pulse),  32'(e.pulse));
        chk({tag, ".err_count"}, 32'(o.cnt),    32'(e.cnt));
`ifdef RING_CHECK_STICKY_ERR_EN
        chk({tag, ".err_sticky"}, 32'(sel ? sticky2 : sticky1), 32'(e.cnt != 8'd0));
`endif
    endtask

    // Drive on the falling edge, score the registered result just after the rising edge.
    task automatic step(input string tag, input bit sel, input logic [3:0] ring,
                        input logic en, input exp_t e);
        exp_t p;
        @(negedge clk);
        if (sel) begin
            ring2 = ring; en2 = en; en1 = 1'b0;
        end else begin
            ring1 = ring; en1 = en; en2 = 1'b0;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        p = sb_q.pop_front();
        chk_all(tag, sel, p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        presetn = 1'b0;
        en1 = 1'b0; en2 = 1'b0;
        ring1 = '0; ring2 = '0;
        #1;
        chk_all("reset1", 1'b0, E(2'd0, 0, 0, 0, 8'd0));
        chk_all("reset2", 1'b1, E(2'd0, 0, 0, 0, 8'd0));
        @(negedge clk);
        presetn = 1'b1;

        // Clean walk and lock after the third sample
        step("walk0", 0, 4'b0001, 1, E(2'd0, 1, 0, 0, 8'd0));
        step("walk1", 0, 4'b0010, 1, E(2'd1, 1, 0, 0, 8'd0));
        step("walk2", 0, 4'b0100, 1, E(2'd2, 1, 1, 0, 8'd0));
        step("walk3", 0, 4'b1000, 1, E(2'd3, 1, 1, 0, 8'd0));
        step("wrap",  0, 4'b0001, 1, E(2'd0, 1, 1, 0, 8'd0));

        // Multi-bit while locked
        step("multi",      0, 4'b0011, 1, E(2'd0, 0, 0, 1, 8'd1));
        step("multi_idle", 0, 4'b0000, 1, E(2'd0, 0, 0, 0, 8'd1));

        // Relock, then preset jump from 0010 to 1000
        step("re0",   0, 4'b0001, 1, E(2'd0, 1, 0, 0, 8'd1));
        step("re1",   0, 4'b0010, 1, E(2'd1, 1, 0, 0, 8'd1));
        step("re2",   0, 4'b0100, 1, E(2'd2, 1, 1, 0, 8'd1));
        step("re3",   0, 4'b1000, 1, E(2'd3, 1, 1, 0, 8'd1));
        step("re4",   0, 4'b0001, 1, E(2'd0, 1, 1, 0, 8'd1));
        step("re5",   0, 4'b0010, 1, E(2'd1, 1, 1, 0, 8'd1));
        step("jump",  0, 4'b1000, 1, E(2'd3, 1, 0, 1, 8'd2));
        step("jmp_a", 0, 4'b0001, 1, E(2'd0, 1, 0, 0, 8'd2));
        step("jmp_b", 0, 4'b0010, 1, E(2'd1, 1, 1, 0, 8'd2));

        // Source cleared: legal, drops lock without error
        for (int k = 0; k < 3; k++)
            step("clear", 0, 4'b0000, 1, E(2'd1, 0, 0, 0, 8'd2));

        // Enable low holds state; next sample compared against held index
        step("en_a",    0, 4'b0100, 1, E(2'd2, 1, 0, 0, 8'd2));
        step("en_b",    0, 4'b1000, 1, E(2'd3, 1, 0, 0, 8'd2));
        step("en_c",    0, 4'b0001, 1, E(2'd0, 1, 1, 0, 8'd2));
        step("dis_m",   0, 4'b0011, 0, E(2'd0, 0, 1, 0, 8'd2));
        step("dis_o",   0, 4'b0100, 0, E(2'd0, 0, 1, 0, 8'd2));
        step("resume",  0, 4'b0010, 1, E(2'd1, 1, 1, 0, 8'd2));
        step("hold",    0, 4'b0010, 1, E(2'd1, 1, 0, 1, 8'd3));
        step("back",    0, 4'b0001, 1, E(2'd0, 1, 0, 0, 8'd3));
        step("acq_a",   0, 4'b0010, 1, E(2'd1, 1, 0, 0, 8'd3));
        step("acq_b",   0, 4'b0100, 1, E(2'd2, 1, 1, 0, 8'd3));

        // Asynchronous reset between edges
        #1 presetn = 1'b0;
        #1 chk_all("async_rst", 1'b0, E(2'd0, 0, 0, 0, 8'd0));
        #1 presetn = 1'b1;
        step("post0", 0, 4'b0100, 1, E(2'd2, 1, 0, 0, 8'd0));
        step("post1", 0, 4'b1000, 1, E(2'd3, 1, 0, 0, 8'd0));
        step("post2", 0, 4'b0001, 1, E(2'd0, 1, 1, 0, 8'd0));

        // Saturation on the 2-bit counter instance
        step("sat_m1", 1, 4'b0110, 1, E(2'd0, 0, 0, 1, 8'd1));
        step("sat_z1", 1, 4'b0000, 1, E(2'd0, 0, 0, 0, 8'd1));
        step("sat_m2", 1, 4'b0110, 1, E(2'd0, 0, 0, 1, 8'd2));
        step("sat_z2", 1, 4'b0000, 1, E(2'd0, 0, 0, 0, 8'd2));
        step("sat_m3", 1, 4'b0110, 1, E(2'd0, 0, 0, 1, 8'd3));
        step("sat_z3", 1, 4'b0000, 1, E(2'd0, 0, 0, 0, 8'd3));
        step("sat_m4", 1, 4'b0110, 1, E(2'd0, 0, 0, 1, 8'd3));
        step("sat_z4", 1, 4'b0000, 1, E(2'd0, 0, 0, 0, 8'd3));
        step("sat_m5", 1, 4'b0110, 1, E(2'd0, 0, 0, 1, 8'd3));
        step("sat_z5", 1, 4'b0000, 1, E(2'd0, 0, 0, 0, 8'd3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
